// File: rtl/fifo_write_logic_pkg.sv
// Shared definitions for the packet-aware FIFO write/read control blocks:
// FSM state encoding and default geometry.
package fifo_write_logic_pkg;

   // Default geometry: DEPTH must equal 2**PTR_SZ.
   localparam int DEF_DEPTH  = 8;
   localparam int DEF_PTR_SZ = 3;
   localparam int DEF_DATA_W = 8;

   // Packet framing state of the write side.
   typedef enum logic [1:0] {
      IDLE = 2'd0,   // between packets, spec_ptr == com_ptr
      RECV = 2'd1,   // inside a packet, bytes pending commit
      DROP = 2'd2    // discarding the rest of an oversize packet
   } state_t;

endpackage

// File: rtl/fifo_write_logic_gray_ptr.sv
// PTR_SZ+1 bit binary pointer with increment, rewind/load and a registered
// Gray-coded copy. The Gray copy is computed from the next value, so it
// changes on the same edge as the binary pointer.
module fifo_write_logic_gray_ptr
   import fifo_write_logic_pkg::*;
#(
   parameter int W = DEF_PTR_SZ + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] bin,
   output logic [W-1:0] gray
);

   logic [W-1:0] nxt;

   // Next pointer value: load has priority over increment.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      nxt = bin;
      if (load) begin
         nxt = load_val;
      end else if (inc) begin
         nxt = bin + {{(W-1){1'b0}}, 1'b1};
      end
   end

   // Pointer register and its Gray image, synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         bin  <= '0;
         gray <= '0;
      end else begin
         bin  <= nxt;
         gray <= nxt ^ (nxt >> 1);
      end
   end

endmodule

// File: rtl/fifo_write_logic.sv
// Packet-aware write side of the router pointer FIFO. Bytes are written
// speculatively; the committed pointer only advances on the last byte of a
// packet, and only its Gray image is published to the read side. Packets
// that cannot fit in the FIFO are dropped instead of deadlocking.
module fifo_write_logic
   import fifo_write_logic_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int PTR_SZ = DEF_PTR_SZ,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wvalid,
   input  logic [DATA_W-1:0] wdata_in,
   input  logic              wlast,
   output logic              wready,
   input  logic [PTR_SZ:0]   wq2_rptr,
   output logic              write_en,
   output logic [PTR_SZ-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic [PTR_SZ:0]   waddr_gray,
   output logic              wfull,
   output logic              pkt_drop
);

   // DEPTH expressed in pointer width (the wrap bit makes this representable).
   localparam logic [PTR_SZ:0] DEPTH_P = (PTR_SZ + 1)'(DEPTH);
   localparam logic [PTR_SZ:0] PTR_ONE = {{PTR_SZ{1'b0}}, 1'b1};

   // Gray to binary: each binary bit is the XOR of all Gray bits above and at it.
   function automatic logic [PTR_SZ:0] gray2bin(input logic [PTR_SZ:0] g);
      logic [PTR_SZ:0] b;
      b[PTR_SZ] = g[PTR_SZ];
      for (int i = PTR_SZ - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   state_t          state;
   logic [PTR_SZ:0] spec_ptr;
   logic [PTR_SZ:0] com_ptr;
   logic [PTR_SZ:0] spec_gray_unused;
   logic [PTR_SZ:0] rptr_bin;
   logic            full_raw;
   logic            pending_full;
   logic            acc;
   logic            commit;
   logic            oversize;

   // Full/ready decode: combinational so a read advance frees space at once.
   always_comb begin
      rptr_bin     = gray2bin(wq2_rptr);
      full_raw     = (spec_ptr - rptr_bin) == DEPTH_P;
      pending_full = (spec_ptr - com_ptr) == DEPTH_P;
      wfull        = rst && full_raw;
      wready       = rst && ((state == DROP) || !full_raw);
      acc          = wvalid && wready;
      write_en     = acc && (state != DROP);
      commit       = write_en && wlast;
      // The packet alone already fills the FIFO, so it can never complete.
      oversize     = rst && (state == RECV) && wvalid && full_raw && pending_full;
      waddr        = rst ? spec_ptr[PTR_SZ-1:0] : '0;
      wdata        = wdata_in;
   end

   // Speculative pointer: advances per written byte, rewinds on a drop.
   fifo_write_logic_gray_ptr #(
      .W (PTR_SZ + 1)
   ) u_spec_ptr (
      .clk      (clk),
      .rst      (rst),
      .inc      (write_en),
      .load     (oversize),
      .load_val (com_ptr),
      .bin      (spec_ptr),
      .gray     (spec_gray_unused)
   );

   // Committed pointer: jumps past the last byte of a complete packet.
   fifo_write_logic_gray_ptr #(
      .W (PTR_SZ + 1)
   ) u_com_ptr (
      .clk      (clk),
      .rst      (rst),
      .inc      (1'b0),
      .load     (commit),
      .load_val (spec_ptr + PTR_ONE),
      .bin      (com_ptr),
      .gray     (waddr_gray)
   );

   // Packet framing FSM with registered drop pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         pkt_drop <= 1'b0;
      end else begin
         pkt_drop <= 1'b0;
         case (state)
            IDLE: begin
               if (acc && !wlast) begin
                  state <= RECV;
               end
            end
            RECV: begin
               if (acc && wlast) begin
                  state <= IDLE;
               end else if (oversize) begin
                  state    <= DROP;
                  pkt_drop <= 1'b1;
               end
            end
            DROP: begin
               if (acc && wlast) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_write_logic.sv
// Self-checking bench for fifo_write_logic (DEPTH=8, PTR_SZ=3). A byte-count
// model predicts every output each cycle; directed scenarios add literal
// expectations on addresses, published pointers and drop pulses.
module tb_fifo_write_logic;

   localparam int DEPTH  = 8;
   localparam int PTR_SZ = 3;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              wvalid = 1'b0;
   logic [DATA_W-1:0] wdata_in = '0;
   logic              wlast = 1'b0;
   logic [PTR_SZ:0]   wq2_rptr = '0;
   logic              wready;
   logic              write_en;
   logic [PTR_SZ-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [PTR_SZ:0]   waddr_gray;
   logic              wfull;
   logic              pkt_drop;

   fifo_write_logic #(
      .DEPTH  (DEPTH),
      .PTR_SZ (PTR_SZ),
      .DATA_W (DATA_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wvalid     (wvalid),
      .wdata_in   (wdata_in),
      .wlast      (wlast),
      .wready     (wready),
      .wq2_rptr   (wq2_rptr),
      .write_en   (write_en),
      .waddr      (waddr),
      .wdata      (wdata),
      .waddr_gray (waddr_gray),
      .wfull      (wfull),
      .pkt_drop   (pkt_drop)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_wr: bytes written so far (mod 16), m_com: bytes committed (mod 16).
   int m_wr = 0;
   int m_com = 0;
   bit m_drop = 0;
   bit m_pulse = 0;
   bit m_live = 0;

   int addr_log[$];
   int drop_count = 0;

   function automatic int g2b(input int g);
      int b = 0;
      for (int i = 0; i < 4; i++) b = b ^ (g >> i);
      return b & 15;
   endfunction

   function automatic bit m_full();
      return ((m_wr - g2b(int'(wq2_rptr))) & 15) == DEPTH;
   endfunction

   // Model update on the active edge, using pre-edge inputs.
   always @(posedge clk) begin : model_upd
      bit full;
      bit acc;
      if (!rst) begin
         m_wr = 0; m_com = 0; m_drop = 0; m_pulse = 0; m_live = 1;
      end else begin
         full = m_full();
         acc = wvalid && (m_drop || !full);
         m_pulse = 0;
         if (m_drop) begin
            if (acc && wlast) m_drop = 0;
         end else if (acc) begin
            m_wr = (m_wr + 1) & 15;
            if (wlast) m_com = m_wr;
         end else if (wvalid && full && ((m_wr - m_com) & 15) == DEPTH) begin
            m_wr = m_com;
            m_drop = 1;
            m_pulse = 1;
         end
      end
   end

   // Compare process on the opposite edge.
   always @(negedge clk) begin : model_cmp
      bit e_full;
      bit e_ready;
      bit e_wen;
      if (m_live) begin
         e_full  = rst && m_full();
         e_ready = rst && (m_drop || !m_full());
         e_wen   = wvalid && e_ready && !m_drop;
         check("mdl_wfull", 32'(wfull), 32'(e_full));
         check("mdl_wready", 32'(wready), 32'(e_ready));
         check("mdl_write_en", 32'(write_en), 32'(e_wen));
         check("mdl_waddr", 32'(waddr), rst ? 32'(m_wr & 7) : 32'd0);
         check("mdl_waddr_gray", 32'(waddr_gray), 32'(m_com ^ (m_com >> 1)));
         check("mdl_pkt_drop", 32'(pkt_drop), 32'(m_pulse));
         if (e_wen) check("mdl_wdata", 32'(wdata), 32'(wdata_in));
         if (write_en === 1'b1) addr_log.push_back(int'(waddr));
         if (pkt_drop === 1'b1) drop_count++;
      end
   end

   // ---------------- stimulus helpers ----------------
   // Present one byte and hold it until accepted; returns #1 after the accepting edge.
   task automatic send_byte(input logic [7:0] d, input logic l);
      bit done = 0;
      int waited = 0;
      wvalid = 1'b1;
      wdata_in = d;
      wlast = l;
      while (!done) begin
         @(negedge clk);
         done = (wready === 1'b1);
         @(posedge clk);
         #1;
         if (!done) begin
            waited++;
            if (waited > 40) begin
               n_checks++;
               n_errors++;
               $display("FAIL send_timeout: byte 0x%0h not accepted within 40 cycles", d);
               done = 1;
            end
         end
      end
   endtask

   task automatic send_pkt(input int len, input logic [7:0] base);
      for (int i = 0; i < len; i++) send_byte(base + 8'(i), (i == len - 1));
      wvalid = 1'b0;
      wlast = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      wvalid = 1'b0;
      wlast = 1'b0;
      wq2_rptr = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      addr_log.delete();
      drop_count = 0;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      // 1. Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_waddr", 32'(waddr), 32'd0);
      check("rst_gray", 32'(waddr_gray), 32'd0);
      check("rst_wfull", 32'(wfull), 32'd0);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_pkt_drop", 32'(pkt_drop), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_release_wready", 32'(wready), 32'd1);

      // 2. One 4-byte packet; commit visible the cycle after wlast.
      for (int i = 0; i < 3; i++) send_byte(8'h10 + 8'(i), 1'b0);
      check("s2_gray_hold", 32'(waddr_gray), 32'd0);
      send_byte(8'h13, 1'b1);
      wvalid = 1'b0;
      wlast = 1'b0;
      check("s2_gray_commit", 32'(waddr_gray), 32'b0110);
      @(posedge clk);
      #1;
      check("s2_nwrites", 32'(addr_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) check("s2_waddr", 32'(addr_log[i]), 32'(i));

      // 3. Two packets fill the FIFO; a read advance frees it combinationally.
      do_reset();
      send_pkt(4, 8'h20);
      send_pkt(4, 8'h30);
      #1;
      check("s3_wfull", 32'(wfull), 32'd1);
      check("s3_wready_low", 32'(wready), 32'd0);
      wq2_rptr = 4'b0110;
      #1;
      check("s3_wfull_clr", 32'(wfull), 32'd0);
      check("s3_wready_up", 32'(wready), 32'd1);

      // 4. Oversize 10-byte packet is dropped; the next packet reuses address 0.
      do_reset();
      send_pkt(10, 8'h40);
      check("s4_gray_nocommit", 32'(waddr_gray), 32'd0);
      check("s4_nwrites", 32'(addr_log.size()), 32'd8);
      for (int i = 0; i < 8; i++) check("s4_waddr", 32'(addr_log[i]), 32'(i));
      send_pkt(2, 8'h50);
      repeat (3) @(posedge clk);
      #1;
      check("s4_drop_pulses", 32'(drop_count), 32'd1);
      check("s4_nwrites2", 32'(addr_log.size()), 32'd10);
      check("s4_next_addr0", 32'(addr_log[8]), 32'd0);
      check("s4_next_addr1", 32'(addr_log[9]), 32'd1);
      check("s4_gray_next", 32'(waddr_gray), 32'b0011);

      // 5. Backpressure mid-packet (not oversize), resume on read advance.
      do_reset();
      send_pkt(4, 8'h60);
      check("s5_gray_com4", 32'(waddr_gray), 32'b0110);
      for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i), 1'b0);
      wvalid = 1'b1;
      wdata_in = 8'h74;
      wlast = 1'b0;
      #1;
      check("s5_stall_wready", 32'(wready), 32'd0);
      check("s5_stall_wfull", 32'(wfull), 32'd1);
      @(posedge clk);
      #1;
      check("s5_stall_hold", 32'(wready), 32'd0);
      check("s5_no_drop", 32'(drop_count), 32'd0);
      wq2_rptr = 4'b0011;
      #1;
      check("s5_resume_wready", 32'(wready), 32'd1);
      send_byte(8'h74, 1'b0);
      send_byte(8'h75, 1'b1);
      wvalid = 1'b0;
      wlast = 1'b0;
      check("s5_gray_commit", 32'(waddr_gray), 32'b1111);
      check("s5_nwrites", 32'(addr_log.size()), 32'd10);
      check("s5_wrap_addr", 32'(addr_log[8]), 32'd0);

      // 6. Reset mid-packet discards everything.
      do_reset();
      send_byte(8'h80, 1'b0);
      send_byte(8'h81, 1'b0);
      rst = 1'b0;
      wvalid = 1'b0;
      @(posedge clk);
      #1;
      check("s6_gray_rst", 32'(waddr_gray), 32'd0);
      check("s6_wready_rst", 32'(wready), 32'd0);
      check("s6_waddr_rst", 32'(waddr), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      addr_log.delete();
      send_pkt(2, 8'h90);
      check("s6_addr0", 32'(addr_log[0]), 32'd0);
      check("s6_addr1", 32'(addr_log[1]), 32'd1);
      check("s6_gray", 32'(waddr_gray), 32'b0011);

      repeat (2) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
